fifo_ctrl_dp: RTL and testbench

- Sequential control and datapath stage directly downstream of fifo_ns.
- Registers the next_state produced by fifo_ns and maintains head/tail pointers, data_count and an 8-entry register-file array.
- Drives the handshake flags and dout.
- Its state and data_count outputs feed back into fifo_ns, closing the FIFO control loop.

---
 rtl/fifo_ctrl_dp.sv | 137 +++++++++++++
 tb/tb_fifo_ctrl_dp.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_dp.sv
// FIFO control/datapath stage: registers the state chosen by fifo_ns, owns the pointers, occupancy and storage.
// Optional FIFO_DOUT_CLR_EN: when defined, dout returns to zero on every edge that is not a READ.
module fifo_ctrl_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            next_state,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [2:0]            state,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [DATA_WIDTH-1:0] dout
);

    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_NO_OP    = 3'b001,
        ST_WRITE    = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_READ     = 3'b100,
        ST_RD_ERROR = 3'b101
    } state_t;

    localparam int                DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] COUNT_FULL = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] COUNT_ZERO = '0;

    state_t                  state_q, state_d;
    state_t                  eff_state;
    logic [ADDR_WIDTH-1:0]   head_q, head_d;
    logic [ADDR_WIDTH-1:0]   tail_q, tail_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    wr_ack_q, wr_ack_d;
    logic                    wr_err_q, wr_err_d;
    logic                    rd_ack_q, rd_ack_d;
    logic                    rd_err_q, rd_err_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // The requested state is overridden when it cannot legally be honoured.
    always_comb begin
        eff_state = ST_NO_OP;
        case (next_state)
            ST_INIT:     eff_state = ST_INIT;
            ST_NO_OP:    eff_state = ST_NO_OP;
            ST_WRITE:    eff_state = (count_q == COUNT_FULL) ? ST_WR_ERROR : ST_WRITE;
            ST_WR_ERROR: eff_state = ST_WR_ERROR;
            ST_READ:     eff_state = (count_q == COUNT_ZERO) ? ST_RD_ERROR : ST_READ;
            ST_RD_ERROR: eff_state = ST_RD_ERROR;
            default:     eff_state = ST_NO_OP;
        endcase
    end

    always_comb begin
        state_d  = eff_state;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        wr_ack_d = 1'b0;
        wr_err_d = 1'b0;
        rd_ack_d = 1'b0;
        rd_err_d = 1'b0;
        mem_we   = 1'b0;
`ifdef FIFO_DOUT_CLR_EN
        dout_d   = '0;
`else
        dout_d   = dout_q;
`endif
        case (eff_state)
            ST_WRITE: begin
                mem_we   = 1'b1;
                tail_d   = tail_q + 1'b1;
                count_d  = count_q + 1'b1;
                wr_ack_d = 1'b1;
            end
            ST_READ: begin
                dout_d   = mem_q[head_q];
                head_d   = head_q + 1'b1;
                count_d  = count_q - 1'b1;
                rd_ack_d = 1'b1;
            end
            ST_WR_ERROR: wr_err_d = 1'b1;
            ST_RD_ERROR: rd_err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_INIT;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is deliberately left out of reset; the write is gated off while reset is held.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we) begin
            mem_q[tail_q] <= din;
        end
    end

    assign state      = state_q;
    assign data_count = count_q;
    assign full       = (count_q == COUNT_FULL);
    assign empty      = (count_q == COUNT_ZERO);
    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign rd_ack     = rd_ack_q;
    assign rd_err     = rd_err_q;
    assign dout       = dout_q;

endmodule

// File: tb/tb_fifo_ctrl_dp.sv
// Bench for fifo_ctrl_dp: directed and random requests compared against a queue-based FIFO model.
module tb_fifo_ctrl_dp;

    logic        clk;
    logic        reset_n;
    logic [2:0]  next_state;
    logic [31:0] din;
    logic [2:0]  state;
    logic [3:0]  data_count;
    logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
    logic [31:0] dout;

    int passCount  = 0;
    int checkCount = 0;

    logic [31:0] modelQ[$];
    logic [2:0]  expState;
    logic        expWrAck, expWrErr, expRdAck, expRdErr;
    logic [31:0] expDout;

    fifo_ctrl_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset_n(reset_n), .next_state(next_state), .din(din),
        .state(state), .data_count(data_count), .full(full), .empty(empty),
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err),
        .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic checkOutput(input string step);
        checkVal({step, ".state"}, {29'd0, state}, {29'd0, expState});
        checkVal({step, ".data_count"}, {28'd0, data_count}, modelQ.size());
        checkVal({step, ".full"}, {31'd0, full}, {31'd0, modelQ.size() == 8});
        checkVal({step, ".empty"}, {31'd0, empty}, {31'd0, modelQ.size() == 0});
        checkVal({step, ".wr_ack"}, {31'd0, wr_ack}, {31'd0, expWrAck});
        checkVal({step, ".wr_err"}, {31'd0, wr_err}, {31'd0, expWrErr});
        checkVal({step, ".rd_ack"}, {31'd0, rd_ack}, {31'd0, expRdAck});
        checkVal({step, ".rd_err"}, {31'd0, rd_err}, {31'd0, expRdErr});
        checkVal({step, ".dout"}, dout, expDout);
    endtask

    // One request per clock: drive on the falling edge, update the model at the rising edge, check 1ns later.
    task automatic applyStimulus(input string step, input logic [2:0] ns, input logic [31:0] d);
        logic [2:0] eff;
        @(negedge clk);
        next_state = ns;
        din        = d;
        @(posedge clk);
        if (ns == 3'b010)      eff = (modelQ.size() == 8) ? 3'b011 : 3'b010;
        else if (ns == 3'b100) eff = (modelQ.size() == 0) ? 3'b101 : 3'b100;
        else if (ns >= 3'd6)   eff = 3'b001;
        else                   eff = ns;
        expState = eff;
        expWrAck = (eff == 3'b010);
        expWrErr = (eff == 3'b011);
        expRdAck = (eff == 3'b100);
        expRdErr = (eff == 3'b101);
        if (eff == 3'b010) modelQ.push_back(d);
        if (eff == 3'b100) expDout = modelQ.pop_front();
`ifdef FIFO_DOUT_CLR_EN
        else expDout = 32'd0;
`endif
        #1;
        checkOutput(step);
    endtask

    // Reset is dropped between edges and checked before any clock edge can occur.
    task automatic applyReset(input string step);
        @(negedge clk);
        #2;
        reset_n    = 1'b0;
        next_state = 3'b001;
        #1;
        modelQ.delete();
        expState = 3'b000;
        expWrAck = 1'b0;
        expWrErr = 1'b0;
        expRdAck = 1'b0;
        expRdErr = 1'b0;
        expDout  = 32'd0;
        checkOutput(step);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b1;
        next_state = 3'b001;
        din        = 32'd0;
        #3;
        reset_n = 1'b0;
        #1;
        modelQ.delete();
        expState = 3'b000;
        expWrAck = 1'b0; expWrErr = 1'b0; expRdAck = 1'b0; expRdErr = 1'b0;
        expDout  = 32'd0;
        checkOutput("reset0");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 1; i <= 8; i++) applyStimulus("fill", 3'b010, 32'h11 * i);
        applyStimulus("fill9", 3'b010, 32'hDEAD_BEEF);
        for (int i = 1; i <= 8; i++) applyStimulus("drain", 3'b100, 32'd0);
        applyStimulus("drain9", 3'b100, 32'd0);

        for (int i = 0; i < 5; i++) applyStimulus("wrapW5", 3'b010, 32'hA000_0000 + i);
        for (int i = 0; i < 5; i++) applyStimulus("wrapR5", 3'b100, 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus("wrapW6", 3'b010, 32'hB000_0000 + i);
        for (int i = 0; i < 6; i++) applyStimulus("wrapR6", 3'b100, 32'd0);

        applyStimulus("noop", 3'b001, 32'd5);
        applyStimulus("ill111", 3'b111, 32'd6);
        applyStimulus("ill110", 3'b110, 32'd7);
        applyStimulus("reqWrErr", 3'b011, 32'd8);
        applyStimulus("reqRdErr", 3'b101, 32'd9);
        applyStimulus("init", 3'b000, 32'd10);

        for (int i = 0; i < 3; i++) applyStimulus("preRst", 3'b010, $urandom);
        applyReset("midReset");
        applyStimulus("postRstRd", 3'b100, 32'd0);
        applyStimulus("postRstWr", 3'b010, 32'hCAFE_0001);
        applyStimulus("postRstRd2", 3'b100, 32'd0);

        // Write-biased then read-biased random phases so both full and empty boundaries get exercised.
        for (int i = 0; i < 300; i++) begin
            logic [2:0] ns;
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 8)       ns = 3'($urandom_range(0, 7));
            else if (i < 150)  ns = (sel < 70) ? 3'b010 : 3'b100;
            else               ns = (sel < 70) ? 3'b100 : 3'b010;
            applyStimulus("rand", ns, $urandom);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
